sweep_peak_tracker: RTL and testbench

// Parametrised two-axis raster sweep engine for the solar-panel optimiser.

---
 rtl/sweep_peak_tracker_if.sv | 43 ++++
 rtl/sweep_peak_tracker.sv | 187 ++++++++++++++++++
 tb/tb_sweep_peak_tracker.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sweep_peak_tracker_if.sv
// sweep_peak_tracker_if
// Bundles the sweep engine's control, ADC sample and result signals.
//   master modport: sequencer / ADC side (drives start, abort, samples;
//                   reads positions, status and peak results)
//   slave  modport: the sweep engine itself
// Signals:
//   start        1-cycle sweep request (ignored while busy)
//   abort        level, ends any sweep and returns to idle
//   sample_valid ADC sample strobe
//   sample_data  ADC sample, unsigned
//   pos_h/pos_v  servo position commands
//   busy         high in every state except idle
//   done         1-cycle pulse when the return-to-peak settle finishes
//   max_v        peak averaged sample of the current/last sweep
//   max_pos_h/v  position at which max_v was taken
//   stat         state code IDLE=0 SETTLE=1 ACQ=2 EVAL=3 STEP=4 RETURN=5 FIN=6
interface sweep_peak_tracker_if #(
  parameter int DATA_W = 12,
  parameter int POS_W  = 32
);
  logic              start;
  logic              abort;
  logic              sample_valid;
  logic [DATA_W-1:0] sample_data;
  logic [POS_W-1:0]  pos_h;
  logic [POS_W-1:0]  pos_v;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] max_v;
  logic [POS_W-1:0]  max_pos_h;
  logic [POS_W-1:0]  max_pos_v;
  logic [2:0]        stat;

  modport master (
    output start, abort, sample_valid, sample_data,
    input  pos_h, pos_v, busy, done, max_v, max_pos_h, max_pos_v, stat
  );

  modport slave (
    input  start, abort, sample_valid, sample_data,
    output pos_h, pos_v, busy, done, max_v, max_pos_h, max_pos_v, stat
  );
endinterface

// File: rtl/sweep_peak_tracker.sv
// sweep_peak_tracker
// Two-axis serpentine raster sweep for the solar-panel optimiser. At every
// raster point it waits SETTLE_CYC cycles, averages 2^AVG_LOG2 ADC samples and
// keeps the peak average with its coordinates; after the last point it drives
// both axes back to the peak, settles, and pulses done.
// Ports:
//   clk  system clock
//   rst  synchronous reset, active-high, overrides everything
//   bus  sweep_peak_tracker_if.slave (start/abort/samples in, positions,
//        status and peak results out)
module sweep_peak_tracker #(
  parameter int          DATA_W     = 12,
  parameter int          POS_W      = 32,
  parameter int unsigned H_MIN      = 0,
  parameter int unsigned H_MAX      = 200,
  parameter int unsigned H_STEP     = 10,
  parameter int unsigned V_MIN      = 0,
  parameter int unsigned V_MAX      = 100,
  parameter int unsigned V_STEP     = 10,
  parameter int unsigned SETTLE_CYC = 1000,
  parameter int          AVG_LOG2   = 2,
  parameter int unsigned HYST       = 0
) (
  input logic                 clk,
  input logic                 rst,
  sweep_peak_tracker_if.slave bus
);

  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);

  localparam logic [POS_W-1:0] H_MIN_P  = POS_W'(H_MIN);
  localparam logic [POS_W-1:0] V_MIN_P  = POS_W'(V_MIN);
  localparam logic [POS_W-1:0] H_STEP_P = POS_W'(H_STEP);
  localparam logic [POS_W-1:0] V_STEP_P = POS_W'(V_STEP);

  // One extra bit on every raster compare so position + step cannot wrap.
  localparam logic [POS_W:0] H_MIN_X  = (POS_W+1)'(H_MIN);
  localparam logic [POS_W:0] H_MAX_X  = (POS_W+1)'(H_MAX);
  localparam logic [POS_W:0] H_STEP_X = (POS_W+1)'(H_STEP);
  localparam logic [POS_W:0] V_MAX_X  = (POS_W+1)'(V_MAX);
  localparam logic [POS_W:0] V_STEP_X = (POS_W+1)'(V_STEP);
  localparam logic [DATA_W:0] HYST_X  = (DATA_W+1)'(HYST);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_ACQ    = 3'd2,
    S_EVAL   = 3'd3,
    S_STEP   = 3'd4,
    S_RETURN = 3'd5,
    S_FIN    = 3'd6
  } state_t;

  state_t            state, state_n;
  logic [POS_W-1:0]  pos_h, pos_v, max_pos_h, max_pos_v;
  logic [DATA_W-1:0] max_v;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  cnt;
  logic [SET_W-1:0]  settle_cnt;
  logic              dir;    // 0: moving toward H_MAX, 1: moving toward H_MIN
  logic              first;  // next evaluated point is the first of the sweep

  logic              busy_c, done_c;
  logic              settle_end, last_sample, h_ok, v_ok, better;
  logic [DATA_W-1:0] avg;

  // Truncating average of the accumulated samples.
  function automatic logic [DATA_W-1:0] avg_of(input logic [ACC_W-1:0] a);
    return DATA_W'(a >> AVG_LOG2);
  endfunction

  assign settle_end  = (settle_cnt == SET_LAST);
  assign last_sample = bus.sample_valid && (cnt == CNT_LAST);
  assign h_ok = dir ? ({1'b0, pos_h} >= (H_MIN_X + H_STEP_X))
                    : (({1'b0, pos_h} + H_STEP_X) <= H_MAX_X);
  assign v_ok = (({1'b0, pos_v} + V_STEP_X) <= V_MAX_X);
  assign avg  = avg_of(acc);
  // Strictly greater than max + HYST, so ties keep the earlier point.
  assign better = first || ({1'b0, avg} > ({1'b0, max_v} + HYST_X));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    busy_c  = (state != S_IDLE);
    done_c  = (state == S_FIN);
    case (state)
      S_IDLE:   if (bus.start) state_n = S_SETTLE;
      S_SETTLE: if (settle_end) state_n = S_ACQ;
      S_ACQ:    if (last_sample) state_n = S_EVAL;
      S_EVAL:   state_n = S_STEP;
      S_STEP:   state_n = (h_ok || v_ok) ? S_SETTLE : S_RETURN;
      S_RETURN: if (settle_end) state_n = S_FIN;
      S_FIN:    state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
    // Abort wins over every transition; in idle it also blocks start.
    if (bus.abort) state_n = (state == S_IDLE) ? S_IDLE : S_IDLE;
  end

  // Datapath: everything freezes while abort is asserted, so positions and
  // peak results hold exactly where the aborted sweep left them.
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_h      <= H_MIN_P;
      pos_v      <= V_MIN_P;
      max_v      <= '0;
      max_pos_h  <= H_MIN_P;
      max_pos_v  <= V_MIN_P;
      acc        <= '0;
      cnt        <= '0;
      settle_cnt <= '0;
      dir        <= 1'b0;
      first      <= 1'b0;
    end else if (!bus.abort) begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            pos_h      <= H_MIN_P;
            pos_v      <= V_MIN_P;
            dir        <= 1'b0;
            max_v      <= '0;
            first      <= 1'b1;
            settle_cnt <= '0;
          end
        end
        S_SETTLE: begin
          if (settle_end) begin
            acc <= '0;
            cnt <= '0;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        S_ACQ: begin
          if (bus.sample_valid) begin
            acc <= acc + ACC_W'(bus.sample_data);
            cnt <= cnt + 1'b1;
          end
        end
        S_EVAL: begin
          if (better) begin
            max_v     <= avg;
            max_pos_h <= pos_h;
            max_pos_v <= pos_v;
          end
          first <= 1'b0;
        end
        S_STEP: begin
          settle_cnt <= '0;
          if (h_ok) begin
            pos_h <= dir ? (pos_h - H_STEP_P) : (pos_h + H_STEP_P);
          end else if (v_ok) begin
            pos_v <= pos_v + V_STEP_P;
            dir   <= ~dir;
          end else begin
            // Raster exhausted: head back to the peak and settle there.
            pos_h <= max_pos_h;
            pos_v <= max_pos_v;
          end
        end
        S_RETURN: begin
          if (!settle_end) settle_cnt <= settle_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.pos_h     = pos_h;
  assign bus.pos_v     = pos_v;
  assign bus.max_v     = max_v;
  assign bus.max_pos_h = max_pos_h;
  assign bus.max_pos_v = max_pos_v;
  assign bus.busy      = busy_c;
  assign bus.done      = done_c;
  assign bus.stat      = state;

endmodule

// File: tb/tb_sweep_peak_tracker.sv
// tb_sweep_peak_tracker
// Drives sweep_peak_tracker on a 3x2 window (H 0..4 step 2, V 0..2 step 2)
// with directed and random sample tables and compares against a reference
// built from the raster rules: serpentine visit list, per-point average and
// peak selection.
module tb_sweep_peak_tracker;

  localparam int          DW     = 12;
  localparam int          PW     = 16;
  localparam int unsigned HMIN   = 0;
  localparam int unsigned HMAX   = 4;
  localparam int unsigned HSTEP  = 2;
  localparam int unsigned VMIN   = 0;
  localparam int unsigned VMAX   = 2;
  localparam int unsigned VSTEP  = 2;
  localparam int unsigned SETTLE = 4;
  localparam int          AVG    = 1;
  localparam int unsigned HYST   = 0;
  localparam int NS = 1 << AVG;
  localparam int NH = (HMAX - HMIN) / HSTEP + 1;
  localparam int NV = (VMAX - VMIN) / VSTEP + 1;
  localparam int NP = NH * NV;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sweep_peak_tracker_if #(.DATA_W(DW), .POS_W(PW)) bus ();

  sweep_peak_tracker #(
    .DATA_W(DW), .POS_W(PW),
    .H_MIN(HMIN), .H_MAX(HMAX), .H_STEP(HSTEP),
    .V_MIN(VMIN), .V_MAX(VMAX), .V_STEP(VSTEP),
    .SETTLE_CYC(SETTLE), .AVG_LOG2(AVG), .HYST(HYST)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  int unsigned smp   [NP][NS];
  int unsigned ord_h [NP];
  int unsigned ord_v [NP];
  int unsigned vis_h [$];
  int unsigned vis_v [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Serpentine visit list: even rows left-to-right, odd rows right-to-left.
  function automatic void build_order();
    for (int r = 0; r < NV; r++) begin
      for (int k = 0; k < NH; k++) begin
        int p;
        p = r * NH + k;
        ord_v[p] = VMIN + r * VSTEP;
        ord_h[p] = (r % 2 == 0) ? HMIN + k * HSTEP : HMIN + (NH - 1 - k) * HSTEP;
      end
    end
  endfunction

  // Peak = first point, replaced only by an average strictly above max+HYST.
  task automatic model_peak(output int unsigned mv, output int unsigned mh, output int unsigned mvp);
    mv = 0; mh = HMIN; mvp = VMIN;
    for (int p = 0; p < NP; p++) begin
      int unsigned sum;
      int unsigned a;
      sum = 0;
      for (int k = 0; k < NS; k++) sum += smp[p][k];
      a = sum / NS;
      if (p == 0 || a > mv + HYST) begin
        mv = a; mh = ord_h[p]; mvp = ord_v[p];
      end
    end
  endtask

  task automatic fill(input int unsigned lo, input int unsigned hi);
    for (int p = 0; p < NP; p++)
      for (int k = 0; k < NS; k++)
        smp[p][k] = $urandom_range(hi, lo);
  endtask

  // One sweep. noisy: sample_valid toggles with junk data outside ACQ.
  // abort_pt / rst_pt / mstart_pt: point index at which to abort (at ACQ
  // entry), reset (during settle) or pulse a stray start; -1 disables.
  task automatic run_sweep(input bit noisy, input int abort_pt, input int rst_pt,
                           input int mstart_pt);
    int npts, cyc, done_cnt;
    bit fin;
    int unsigned mv, mh, mvp;
    npts = 0; cyc = 0; done_cnt = 0; fin = 1'b0;
    model_peak(mv, mh, mvp);
    vis_h.delete(); vis_v.delete();
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    chk("start_stat", bus.stat, 1);
    chk("start_maxv", bus.max_v, 0);
    chk("start_pos_h", bus.pos_h, HMIN);
    chk("start_pos_v", bus.pos_v, VMIN);
    while (!fin && cyc < 3000) begin
      if (bus.stat == 3'd2 && npts < NP) begin
        vis_h.push_back(bus.pos_h); vis_v.push_back(bus.pos_v);
        if (npts == abort_pt) begin
          int unsigned seen_done;
          seen_done = 0;
          bus.sample_valid = 1'b1; bus.sample_data = DW'(smp[npts][0]);
          bus.abort = 1'b1; tick(); bus.abort = 1'b0; bus.sample_valid = 1'b0;
          chk("abort_stat", bus.stat, 0);
          chk("abort_busy", bus.busy, 0);
          for (int i = 0; i < 6; i++) begin
            if (bus.done) seen_done++;
            tick();
          end
          chk("abort_no_done", seen_done, 0);
          chk("abort_idle", bus.stat, 0);
          chk("abort_pos_h", bus.pos_h, ord_h[abort_pt]);
          chk("abort_pos_v", bus.pos_v, ord_v[abort_pt]);
          return;
        end
        for (int k = 0; k < NS; k++) begin
          bus.sample_valid = 1'b0;
          repeat ($urandom_range(2, 0)) begin tick(); cyc++; end
          bus.sample_valid = 1'b1; bus.sample_data = DW'(smp[npts][k]);
          tick(); cyc++;
        end
        bus.sample_valid = 1'b0;
        chk("eval_after_last_sample", bus.stat, 3);
        npts++;
      end else begin
        if (npts == rst_pt && bus.stat == 3'd1) begin
          rst = 1'b1; tick(); rst = 1'b0;
          chk("rst_stat", bus.stat, 0);
          chk("rst_busy", bus.busy, 0);
          chk("rst_done", bus.done, 0);
          chk("rst_pos_h", bus.pos_h, HMIN);
          chk("rst_pos_v", bus.pos_v, VMIN);
          chk("rst_maxv", bus.max_v, 0);
          chk("rst_max_pos_h", bus.max_pos_h, HMIN);
          chk("rst_max_pos_v", bus.max_pos_v, VMIN);
          return;
        end
        bus.sample_valid = noisy;
        if (noisy) bus.sample_data = DW'($urandom);
        bus.start = (npts == mstart_pt && bus.stat == 3'd1);
        tick(); cyc++;
        bus.start = 1'b0;
        if (bus.done) begin
          done_cnt++;
          chk("done_stat", bus.stat, 6);
          chk("done_pos_h", bus.pos_h, mh);
          chk("done_pos_v", bus.pos_v, mvp);
        end else if (done_cnt > 0) begin
          fin = 1'b1;
        end
      end
    end
    bus.sample_valid = 1'b0;
    chk("sweep_finished", fin, 1);
    chk("done_pulses", done_cnt, 1);
    chk("visit_count", vis_h.size(), NP);
    for (int p = 0; p < NP && p < vis_h.size(); p++) begin
      chk($sformatf("visit%0d_h", p), vis_h[p], ord_h[p]);
      chk($sformatf("visit%0d_v", p), vis_v[p], ord_v[p]);
    end
    chk("max_v", bus.max_v, mv);
    chk("max_pos_h", bus.max_pos_h, mh);
    chk("max_pos_v", bus.max_pos_v, mvp);
    chk("idle_stat", bus.stat, 0);
    chk("idle_busy", bus.busy, 0);
    tick(); tick();
    chk("hold_pos_h", bus.pos_h, mh);
    chk("hold_pos_v", bus.pos_v, mvp);
  endtask

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0;
    bus.sample_valid = 1'b0; bus.sample_data = '0;
    build_order();
    rst = 1'b1;
    repeat (3) tick();
    chk("reset_stat", bus.stat, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_pos_h", bus.pos_h, HMIN);
    chk("reset_pos_v", bus.pos_v, VMIN);
    chk("reset_maxv", bus.max_v, 0);
    chk("reset_max_pos_h", bus.max_pos_h, HMIN);
    chk("reset_max_pos_v", bus.max_pos_v, VMIN);
    rst = 1'b0;
    tick();

    // Directed table: peak avg 51 at the fourth visited point (4,2).
    smp[0] = '{10, 10}; smp[1] = '{30, 30}; smp[2] = '{20, 20};
    smp[3] = '{50, 52}; smp[4] = '{5, 5};   smp[5] = '{40, 40};
    run_sweep(1'b0, -1, -1, -1);

    // Strobes during settle and other non-acquire states must be ignored.
    fill(1, 4095);
    run_sweep(1'b1, -1, -1, -1);

    // Ties keep the first point.
    fill(7, 7);
    run_sweep(1'b0, -1, -1, -1);

    // Full-scale samples must not wrap; all-zero keeps the first point.
    fill(4095, 4095);
    run_sweep(1'b1, -1, -1, -1);
    fill(0, 0);
    run_sweep(1'b0, -1, -1, -1);

    // Random tables, small range to provoke ties.
    for (int i = 0; i < 3; i++) begin
      fill(0, 6);
      run_sweep(i[0], -1, -1, -1);
    end

    // Abort at ACQ of (4,0), then a fresh sweep starts clean.
    fill(100, 4000);
    run_sweep(1'b0, 2, -1, -1);
    fill(0, 4095);
    run_sweep(1'b0, -1, -1, -1);

    // Reset in the settle of (4,2) after a non-zero peak has been stored.
    fill(1, 4095);
    run_sweep(1'b0, -1, 3, -1);

    // Stray start during a sweep is ignored.
    fill(0, 4095);
    run_sweep(1'b1, -1, -1, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
